// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER host: image geometry, cover radius,
// host FSM states, error codes and the squared-distance helper.
package laser_pkg;

    localparam int NPTS      = 40;
    localparam int RADIUS_SQ = 16;

    typedef logic [3:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LRESET,
        ST_PREP,
        ST_SEND,
        ST_WAIT,
        ST_SCORE,
        ST_REPORT
    } host_state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_DONE_STUCK = 2'd1,
        ERR_DONE_EARLY = 2'd2
    } err_e;

    // |dx| squared equals the signed dx squared, so magnitudes keep it unsigned.
    function automatic logic [8:0] dist_sq(input pt_t a, input pt_t b);
        coord_t     adx;
        coord_t     ady;
        logic [7:0] sx;
        logic [7:0] sy;
        adx = (a.x > b.x) ? (a.x - b.x) : (b.x - a.x);
        ady = (a.y > b.y) ? (a.y - b.y) : (b.y - a.y);
        sx  = {4'd0, adx} * {4'd0, adx};
        sy  = {4'd0, ady} * {4'd0, ady};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational cover test: a point is covered when it lies within the
// inclusive radius of either centre. Shared with the engine side.
module laser_cover_chk
    import laser_pkg::*;
(
    input  pt_t  pt,
    input  pt_t  c1,
    input  pt_t  c2,
    output logic covered
);

    localparam logic [8:0] RSQ = 9'(RADIUS_SQ);

    logic [8:0] d1_sq;
    logic [8:0] d2_sq;

    assign d1_sq   = dist_sq(pt, c1);
    assign d2_sq   = dist_sq(pt, c2);
    assign covered = (d1_sq <= RSQ) || (d2_sq <= RSQ);

endmodule

// File: rtl/laser_host.sv
// Host/scorer for the LASER engine: resets it, streams the stored image,
// waits for DONE (bounded), then scores the returned centres point by point.
module laser_host
    import laser_pkg::*;
#(
    parameter int TIMEOUT       = 50000,
    parameter int DONE_LOW_WAIT = 11,
    parameter int CYC_W         = 17
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             pt_we,
    input  logic [5:0]       pt_addr,
    input  logic [3:0]       pt_x,
    input  logic [3:0]       pt_y,
    output logic             LRST,
    output logic [3:0]       X,
    output logic [3:0]       Y,
    input  logic [3:0]       C1X,
    input  logic [3:0]       C1Y,
    input  logic [3:0]       C2X,
    input  logic [3:0]       C2Y,
    input  logic             DONE,
    output logic             busy,
    output logic             res_valid,
    output logic [5:0]       cover_cnt,
    output logic [CYC_W-1:0] cycles,
    output logic [3:0]       r_c1x,
    output logic [3:0]       r_c1y,
    output logic [3:0]       r_c2x,
    output logic [3:0]       r_c2y,
    output logic             timeout,
    output logic [1:0]       err
);

    localparam int                PREP_W     = $clog2(DONE_LOW_WAIT + 1);
    localparam logic [PREP_W-1:0] PREP_LIMIT = PREP_W'(DONE_LOW_WAIT);
    localparam logic [CYC_W-1:0]  TIMEOUT_C  = CYC_W'(TIMEOUT);
    localparam logic [5:0]        NPTS_C     = 6'(NPTS);
    localparam logic [5:0]        LAST_IDX   = 6'(NPTS - 1);

    pt_t mem [NPTS];

    host_state_e       state_reg;
    logic              lrst_reg;
    logic              lrst_cnt_reg;
    logic [PREP_W-1:0] prep_cnt_reg;
    logic [5:0]        idx_reg;
    coord_t            x_reg;
    coord_t            y_reg;
    logic              busy_reg;
    logic              res_valid_reg;
    logic [5:0]        cover_reg;
    logic [CYC_W-1:0]  cycles_reg;
    pt_t               c1_reg;
    pt_t               c2_reg;
    logic              timeout_reg;
    err_e              err_reg;

    logic [5:0] idx_next;
    pt_t        send_pt;
    pt_t        score_pt;
    logic       covered;

    assign idx_next = idx_reg + 6'd1;
    assign send_pt  = mem[idx_next];
    assign score_pt = mem[idx_reg];

    // Image writes are only honoured while idle so a run always sees a stable image.
    always_ff @(posedge CLK) begin
        if (pt_we && (state_reg == ST_IDLE) && (pt_addr < NPTS_C)) begin
            mem[pt_addr] <= {pt_x, pt_y};
        end
    end

    laser_cover_chk u_cover (
        .pt      (score_pt),
        .c1      (c1_reg),
        .c2      (c2_reg),
        .covered (covered)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            lrst_reg      <= 1'b0;
            lrst_cnt_reg  <= 1'b0;
            prep_cnt_reg  <= '0;
            idx_reg       <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            busy_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            cover_reg     <= '0;
            cycles_reg    <= '0;
            c1_reg        <= '0;
            c2_reg        <= '0;
            timeout_reg   <= 1'b0;
            err_reg       <= ERR_NONE;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_LRESET;
                        lrst_reg     <= 1'b1;
                        lrst_cnt_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        cover_reg    <= '0;
                        cycles_reg   <= '0;
                        timeout_reg  <= 1'b0;
                        err_reg      <= ERR_NONE;
                    end
                end
                ST_LRESET: begin
                    if (lrst_cnt_reg) begin
                        state_reg    <= ST_PREP;
                        lrst_reg     <= 1'b0;
                        prep_cnt_reg <= '0;
                    end else begin
                        lrst_cnt_reg <= 1'b1;
                    end
                end
                ST_PREP: begin
                    if (!DONE) begin
                        state_reg <= ST_SEND;
                        idx_reg   <= '0;
                        x_reg     <= mem[0].x;
                        y_reg     <= mem[0].y;
                    end else if (prep_cnt_reg == PREP_LIMIT) begin
                        state_reg     <= ST_REPORT;
                        err_reg       <= ERR_DONE_STUCK;
                        res_valid_reg <= 1'b1;
                    end else begin
                        prep_cnt_reg <= prep_cnt_reg + PREP_W'(1);
                    end
                end
                ST_SEND: begin
                    if (DONE) begin
                        state_reg     <= ST_REPORT;
                        err_reg       <= ERR_DONE_EARLY;
                        res_valid_reg <= 1'b1;
                        x_reg         <= '0;
                        y_reg         <= '0;
                    end else if (idx_reg == LAST_IDX) begin
                        state_reg <= ST_WAIT;
                        x_reg     <= '0;
                        y_reg     <= '0;
                    end else begin
                        idx_reg <= idx_next;
                        x_reg   <= send_pt.x;
                        y_reg   <= send_pt.y;
                    end
                end
                ST_WAIT: begin
                    // DONE is tested first so it wins over a simultaneous timeout.
                    if (DONE) begin
                        state_reg <= ST_SCORE;
                        idx_reg   <= '0;
                        c1_reg    <= {C1X, C1Y};
                        c2_reg    <= {C2X, C2Y};
                    end else if (cycles_reg == TIMEOUT_C) begin
                        state_reg   <= ST_SCORE;
                        idx_reg     <= '0;
                        cycles_reg  <= cycles_reg + CYC_W'(1);
                        timeout_reg <= 1'b1;
                        c1_reg      <= {C1X, C1Y};
                        c2_reg      <= {C2X, C2Y};
                    end else begin
                        cycles_reg <= cycles_reg + CYC_W'(1);
                    end
                end
                ST_SCORE: begin
                    cover_reg <= cover_reg + {5'd0, covered};
                    if (idx_reg == LAST_IDX) begin
                        state_reg     <= ST_REPORT;
                        res_valid_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_next;
                    end
                end
                ST_REPORT: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign LRST      = lrst_reg;
    assign X         = x_reg;
    assign Y         = y_reg;
    assign busy      = busy_reg;
    assign res_valid = res_valid_reg;
    assign cover_cnt = cover_reg;
    assign cycles    = cycles_reg;
    assign r_c1x     = c1_reg.x;
    assign r_c1y     = c1_reg.y;
    assign r_c2x     = c2_reg.x;
    assign r_c2y     = c2_reg.y;
    assign timeout   = timeout_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: a cycle-schedule model of each run drives a
// mock engine and a per-cycle compare process checks every output.
module tb_laser_host;
    import laser_pkg::*;

    localparam int TIMEOUT = 50000;
    localparam int CYC_W   = 17;

    logic             CLK = 1'b0;
    logic             RST, start, pt_we, DONE;
    logic [5:0]       pt_addr;
    logic [3:0]       pt_x, pt_y, C1X, C1Y, C2X, C2Y;
    logic             LRST, busy, res_valid, timeout;
    logic [3:0]       X, Y, r_c1x, r_c1y, r_c2x, r_c2y;
    logic [5:0]       cover_cnt;
    logic [CYC_W-1:0] cycles;
    logic [1:0]       err;

    always #5 CLK = ~CLK;

    laser_host #(.TIMEOUT(TIMEOUT), .DONE_LOW_WAIT(11), .CYC_W(CYC_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .pt_we(pt_we), .pt_addr(pt_addr),
        .pt_x(pt_x), .pt_y(pt_y), .LRST(LRST), .X(X), .Y(Y),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
        .busy(busy), .res_valid(res_valid), .cover_cnt(cover_cnt), .cycles(cycles),
        .r_c1x(r_c1x), .r_c1y(r_c1y), .r_c2x(r_c2x), .r_c2y(r_c2y),
        .timeout(timeout), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    int img_x [NPTS];
    int img_y [NPTS];

    // Expected per-cycle outputs and held results, written by the driver.
    bit chk_en, res_chk;
    int exp_lrst, exp_busy, exp_rv, exp_x, exp_y;
    int exp_cover, exp_cycles, exp_timeout, exp_err;
    int exp_rc [4];

    function automatic void check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, expv, $time);
        end
    endfunction

    function automatic int model_cover(input int c1x, input int c1y, input int c2x, input int c2y);
        int cnt = 0;
        for (int k = 0; k < NPTS; k++) begin
            int d1 = (img_x[k] - c1x) * (img_x[k] - c1x) + (img_y[k] - c1y) * (img_y[k] - c1y);
            int d2 = (img_x[k] - c2x) * (img_x[k] - c2x) + (img_y[k] - c2y) * (img_y[k] - c2y);
            if (d1 <= RADIUS_SQ || d2 <= RADIUS_SQ) cnt++;
        end
        return cnt;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            check("LRST", int'(LRST), exp_lrst);
            check("X", int'(X), exp_x);
            check("Y", int'(Y), exp_y);
            check("busy", int'(busy), exp_busy);
            check("res_valid", int'(res_valid), exp_rv);
            if (res_chk) begin
                check("cover_cnt", int'(cover_cnt), exp_cover);
                check("cycles", int'(cycles), exp_cycles);
                check("timeout", int'(timeout), exp_timeout);
                check("err", int'(err), exp_err);
                check("r_c1x", int'(r_c1x), exp_rc[0]);
                check("r_c1y", int'(r_c1y), exp_rc[1]);
                check("r_c2x", int'(r_c2x), exp_rc[2]);
                check("r_c2y", int'(r_c2y), exp_rc[3]);
            end
        end
    end

    task automatic set_halves(input int ax, input int ay, input int bx, input int by);
        for (int k = 0; k < NPTS; k++) begin
            img_x[k] = (k < NPTS / 2) ? ax : bx;
            img_y[k] = (k < NPTS / 2) ? ay : by;
        end
    endtask

    task automatic load_img();
        for (int k = 0; k < NPTS; k++) begin
            pt_we = 1'b1; pt_addr = 6'(k); pt_x = 4'(img_x[k]); pt_y = 4'(img_y[k]);
            @(posedge CLK); #1;
        end
        pt_we = 1'b1; pt_addr = 6'd45; pt_x = 4'd9; pt_y = 4'd9;
        @(posedge CLK); #1;
        pt_we = 1'b0;
    endtask

    // mode 0: DONE from cycle 44+wdone; 1: DONE never; 2: DONE stuck high;
    // 3: DONE rises at SEND index 5. Cycle 1 is the first cycle after start is sampled.
    task automatic run(input int mode, input int wdone, input int rst_at, input bit noise,
                       input int c1x, input int c1y, input int c2x, input int c2y);
        int  n, cap_n, rep_n;
        int  cc [4];
        bit  fin, send;
        cap_n = (mode == 0) ? 44 + wdone : (mode == 1) ? 44 + TIMEOUT : -1;
        rep_n = (mode <= 1) ? cap_n + 41 : (mode == 2) ? 15 : 10;
        if (rst_at != 0) rep_n = -1;
        start = 1'b1;
        DONE  = (mode == 2);
        @(posedge CLK); #1;
        start   = 1'b0;
        res_chk = 1'b0;
        n   = 1;
        fin = 1'b0;
        while (!fin) begin
            RST = (n == rst_at);
            case (mode)
                0:       DONE = (n >= cap_n);
                2:       DONE = 1'b1;
                3:       DONE = (n >= 9);
                default: DONE = 1'b0;
            endcase
            if (mode == 1) begin
                C1X = 4'(n); C1Y = 4'(n >> 4); C2X = 4'(n) ^ 4'h5; C2Y = ~4'(n);
            end else begin
                C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
            end
            pt_we = noise; pt_addr = 6'(n % NPTS); pt_x = 4'd9; pt_y = 4'd3;
            send     = (mode != 2) && (n >= 4) && (n <= 43) && ((mode != 3) || (n <= 9));
            exp_lrst = (n <= 2);
            exp_busy = 1;
            exp_rv   = (n == rep_n);
            exp_x    = send ? img_x[n - 4] : 0;
            exp_y    = send ? img_y[n - 4] : 0;
            if (n == cap_n) begin
                cc[0] = int'(C1X); cc[1] = int'(C1Y); cc[2] = int'(C2X); cc[3] = int'(C2Y);
                for (int i = 0; i < 4; i++) exp_rc[i] = cc[i];
            end
            if (n == rep_n) begin
                exp_cover   = (mode <= 1) ? model_cover(cc[0], cc[1], cc[2], cc[3]) : 0;
                exp_cycles  = (mode == 0) ? wdone : (mode == 1) ? TIMEOUT + 1 : 0;
                exp_timeout = (mode == 1);
                exp_err     = (mode == 2) ? 1 : (mode == 3) ? 2 : 0;
                res_chk     = 1'b1;
            end
            @(posedge CLK); #1;
            if (n == rep_n || n == rst_at) fin = 1'b1;
            n++;
        end
        RST = 1'b0; DONE = 1'b0; pt_we = 1'b0;
        exp_lrst = 0; exp_busy = 0; exp_rv = 0; exp_x = 0; exp_y = 0;
        if (rst_at != 0) begin
            exp_cover = 0; exp_cycles = 0; exp_timeout = 0; exp_err = 0;
            for (int i = 0; i < 4; i++) exp_rc[i] = 0;
            res_chk = 1'b1;
        end
        $display("run mode=%0d rst_at=%0d: cover=%0d cycles=%0d timeout=%0d err=%0d c1=(%0d,%0d) c2=(%0d,%0d)",
                 mode, rst_at, cover_cnt, cycles, timeout, err, r_c1x, r_c1y, r_c2x, r_c2y);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; pt_we = 1'b0; pt_addr = '0; pt_x = '0; pt_y = '0;
        C1X = '0; C1Y = '0; C2X = '0; C2Y = '0; DONE = 1'b0;
        chk_en = 1'b0; res_chk = 1'b0;
        exp_lrst = 0; exp_busy = 0; exp_rv = 0; exp_x = 0; exp_y = 0;
        exp_cover = 0; exp_cycles = 0; exp_timeout = 0; exp_err = 0;
        for (int i = 0; i < 4; i++) exp_rc[i] = 0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0; res_chk = 1'b1; chk_en = 1'b1;
        @(posedge CLK); #1;
        check("rst_busy", int'(busy), 0);
        check("rst_cycles", int'(cycles), 0);

        set_halves(5, 5, 5, 5);
        check("model_a", model_cover(5, 5, 0, 0), 40);
        load_img();
        run(0, 100, 0, 1'b0, 5, 5, 0, 0);
        check("t1_cover", int'(cover_cnt), 40);
        check("t1_cycles", int'(cycles), 100);

        set_halves(4, 0, 4, 1);
        check("model_b", model_cover(0, 0, 0, 0), 20);
        load_img();
        run(0, 3, 0, 1'b0, 0, 0, 0, 0);
        check("t2_cover", int'(cover_cnt), 20);

        set_halves(0, 0, 15, 15);
        check("model_c", model_cover(2, 2, 12, 12), 20);
        load_img();
        run(0, 0, 0, 1'b0, 2, 2, 12, 12);
        check("t3_cover", int'(cover_cnt), 20);
        check("t3_r_c2x", int'(r_c2x), 12);

        run(1, 0, 0, 1'b0, 0, 0, 0, 0);
        check("to_cycles", int'(cycles), 50001);
        check("to_flag", int'(timeout), 1);
        check("to_r_c1x", int'(r_c1x), 12);
        check("to_r_c1y", int'(r_c1y), 7);
        check("to_r_c2x", int'(r_c2x), 9);
        check("to_r_c2y", int'(r_c2y), 3);

        run(2, 0, 0, 1'b0, 0, 0, 0, 0);
        check("stuck_err", int'(err), 1);

        run(3, 0, 0, 1'b0, 0, 0, 0, 0);
        check("early_err", int'(err), 2);
        check("early_cover", int'(cover_cnt), 0);

        set_halves(4, 0, 4, 1);
        load_img();
        run(0, 5, 24, 1'b0, 0, 0, 8, 1);
        check("abort_busy", int'(busy), 0);
        run(0, 5, 0, 1'b1, 0, 0, 8, 1);
        check("rerun_cover", int'(cover_cnt), 40);

        repeat (3) @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
